// File: rtl/conv_window_ctrl_pkg.sv
// Purpose : shared types and sizing helpers for the convolution window sequencer.
// Contents: FSM state enum, output-side helper calc_p(), address-width helper
//           addr_w() and default address widths used by the memory wrappers.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Output map side for an n x n input and an m x m kernel.
  function automatic int calc_p(input int n, input int m);
    return n - m + 1;
  endfunction

  // Address width for a memory of 'depth' words; never narrower than 1 bit.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int N_DEF = 8;
  localparam int M_DEF = 3;
  localparam int P_DEF = calc_p(N_DEF, M_DEF);
  localparam int X_AW  = addr_w(N_DEF * N_DEF);
  localparam int W_AW  = addr_w(M_DEF * M_DEF);
  localparam int Y_AW  = addr_w(P_DEF * P_DEF);

endpackage

// File: rtl/conv_window_ctrl_addr_gen.sv
// Purpose : window counters (i,j taps; r,c output pixel) and address arithmetic.
// Latency : addresses are combinational from the counter registers.
// Ports   : clr_i zeroes all counters, tap_adv_i steps j then i, pix_adv_i steps
//           c then r; x/w/y addresses out, last_tap_o / last_pixel_o flags.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clr_i,
  input  logic                                  tap_adv_i,
  input  logic                                  pix_adv_i,
  output logic [addr_w(N*N)-1:0]                x_addr_o,
  output logic [addr_w(M*M)-1:0]                w_addr_o,
  output logic [addr_w(calc_p(N,M)*calc_p(N,M))-1:0] y_addr_o,
  output logic                                  last_tap_o,
  output logic                                  last_pixel_o
);

  localparam int P   = calc_p(N, M);
  localparam int XAW = addr_w(N * N);
  localparam int WAW = addr_w(M * M);
  localparam int YAW = addr_w(P * P);
  localparam int CMW = addr_w(M);
  localparam int CPW = addr_w(P);

  logic [CMW-1:0] i_q, i_d, j_q, j_d;
  logic [CPW-1:0] r_q, r_d, c_q, c_d;

  assign last_tap_o   = (int'(i_q) == M - 1) && (int'(j_q) == M - 1);
  assign last_pixel_o = (int'(r_q) == P - 1) && (int'(c_q) == P - 1);

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    r_d = r_q;
    c_d = c_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      r_d = '0;
      c_d = '0;
    end else begin
      if (tap_adv_i) begin
        if (int'(j_q) == M - 1) begin
          j_d = '0;
          i_d = last_tap_o ? '0 : i_q + CMW'(1);
        end else begin
          j_d = j_q + CMW'(1);
        end
      end
      // Wrapping after the last pixel leaves the counters ready for the next run.
      if (pix_adv_i) begin
        if (int'(c_q) == P - 1) begin
          c_d = '0;
          r_d = last_pixel_o ? '0 : r_q + CPW'(1);
        end else begin
          c_d = c_q + CPW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign x_addr_o = XAW'((int'(r_q) + int'(i_q)) * N + int'(c_q) + int'(j_q));
  assign w_addr_o = WAW'(int'(i_q) * M + int'(j_q));
  assign y_addr_o = YAW'(int'(r_q) * P + int'(c_q));

endmodule

// File: rtl/conv_window_ctrl.sv
// Purpose : sequences an N x N map / M x M kernel convolution through an external
//           MAC and returns (N-M+1)^2 results in row-major order.
// Latency : 1+M*M+2+1 cycles per pixel with y_ready high; first y_valid 4+M*M
//           cycles after the start cycle.
// Backpressure: y_ready low holds y_valid/y_data/y_addr, freezes addresses and
//           keeps both MAC strobes low.
// Ports   : clk/reset (sync, active-low), start/bias/busy/done control, x/w
//           memory address+data, mac_* drive and mac_out return, y_* result stream.
// Option  : CONV_WINDOW_CTRL_RELU_EN clamps negative results to zero.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int N    = 8,
  parameter int M    = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [INW-1:0]                             bias,
  output logic                                       busy,
  output logic                                       done,
  output logic [addr_w(N*N)-1:0]                     x_addr,
  input  logic [INW-1:0]                             x_data,
  output logic [addr_w(M*M)-1:0]                     w_addr,
  input  logic [INW-1:0]                             w_data,
  output logic [INW-1:0]                             mac_in0,
  output logic [INW-1:0]                             mac_in1,
  output logic [INW-1:0]                             mac_init_value,
  output logic                                       mac_init_acc,
  output logic                                       mac_input_valid,
  input  logic [OUTW-1:0]                            mac_out,
  output logic [OUTW-1:0]                            y_data,
  output logic [addr_w(calc_p(N,M)*calc_p(N,M))-1:0] y_addr,
  output logic                                       y_valid,
  input  logic                                       y_ready
);

  localparam int P   = calc_p(N, M);
  localparam int YAW = addr_w(P * P);

  state_e           state_q, state_d;
  logic             drain_q, drain_d;
  logic             issue_q;
  logic [INW-1:0]   bias_q;
  logic [OUTW-1:0]  y_data_q, y_data_d;
  logic [YAW-1:0]   y_addr_q, y_addr_gen;
  logic             clr, tap_adv, pix_adv, bias_load, capture;
  logic             last_tap, last_pixel;

  conv_addr_gen #(
    .N (N),
    .M (M)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (clr),
    .tap_adv_i    (tap_adv),
    .pix_adv_i    (pix_adv),
    .x_addr_o     (x_addr),
    .w_addr_o     (w_addr),
    .y_addr_o     (y_addr_gen),
    .last_tap_o   (last_tap),
    .last_pixel_o (last_pixel)
  );

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    clr       = 1'b0;
    tap_adv   = 1'b0;
    pix_adv   = 1'b0;
    bias_load = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bias_load = 1'b1;
          clr       = 1'b1;
          state_d   = ST_INIT;
        end
      end
      ST_INIT: state_d = ST_ISSUE;
      ST_ISSUE: begin
        tap_adv = 1'b1;
        drain_d = 1'b0;
        if (last_tap) state_d = ST_DRAIN;
      end
      // First drain cycle sees the last data word; the second sees the MAC
      // register holding the complete sum, which is captured on leaving.
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          drain_d = 1'b0;
          capture = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (y_ready) begin
          pix_adv = 1'b1;
          state_d = last_pixel ? ST_DONE : ST_INIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CONV_WINDOW_CTRL_RELU_EN
  assign y_data_d = mac_out[OUTW-1] ? '0 : mac_out;
`else
  assign y_data_d = mac_out;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      drain_q  <= 1'b0;
      issue_q  <= 1'b0;
      bias_q   <= '0;
      y_data_q <= '0;
      y_addr_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      // Memory read latency is one cycle, so the accumulate strobe trails issue.
      issue_q <= (state_q == ST_ISSUE);
      if (bias_load) bias_q <= bias;
      if (capture) begin
        y_data_q <= y_data_d;
        y_addr_q <= y_addr_gen;
      end
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign y_valid         = (state_q == ST_OUT);
  assign mac_init_acc    = (state_q == ST_INIT);
  assign mac_input_valid = issue_q;
  assign mac_init_value  = bias_q;
  assign mac_in0         = x_data;
  assign mac_in1         = w_data;
  assign y_data          = y_data_q;
  assign y_addr          = y_addr_q;

endmodule
